// File: rtl/phy_tx_pkg.sv
// Shared definitions for the TX link sequencer: word width, control symbols
// and the link state encoding.
package phy_tx_pkg;

   localparam int WORD_W = 32;

   localparam logic [7:0] COM_SYM = 8'hBC;
   localparam logic [7:0] IDL_SYM = 8'h7C;
   localparam logic [7:0] SKP_SYM = 8'h1C;

   typedef enum logic [1:0] {
      ST_DOWN  = 2'd0,
      ST_TRAIN = 2'd1,
      ST_RUN   = 2'd2
   } link_state_e;

   // Control words carry one symbol replicated across all four byte lanes.
   function automatic logic [WORD_W-1:0] rep4(input logic [7:0] sym);
      return {4{sym}};
   endfunction

endpackage

// File: rtl/phy_tx_wrap_cnt.sv
// Free-running counter over 0..MAX-1 with synchronous clear and a
// terminal-count flag raised while the count sits at MAX-1.
module phy_tx_wrap_cnt #(
   parameter int MAX = 16,
   localparam int CW = (MAX > 1) ? $clog2(MAX) : 1
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic inc,
   output logic tc
);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign tc = (cnt_q == CW'(MAX - 1));

   // NOTE: cnt_d is given its hold value before any branch, so every path
   // assigns it and no latch can be inferred.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc) begin
         cnt_d = tc ? '0 : cnt_q + CW'(1);
      end
   end

   // NOTE: state is updated with non-blocking assignments so every flop
   // samples the pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/phy_tx_link_ctrl.sv
// Link sequencer ahead of the TX striping stage: trains with COM words, then
// forwards requester words, filling gaps with IDL and pacing SKP insertion.
module phy_tx_link_ctrl
   import phy_tx_pkg::*;
#(
   parameter int TRAIN_LEN     = 16,
   parameter int SKIP_INTERVAL = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [WORD_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [WORD_W-1:0] data_out,
   output logic              valid_out,
   output logic              k_out,
   output logic              link_up,
   output logic [15:0]       words_sent
);

   link_state_e       state_q, state_d;
   logic [WORD_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;
   logic              k_q, k_d;
   logic              link_up_q, link_up_d;
   logic [15:0]       words_q, words_d;

   logic train_tc;
   logic skip_due;
   logic train_clr;
   logic skip_clr;

   // Counters only run while their state is held with enable high, so a
   // dropped enable restarts training and realigns SKP pacing on re-entry.
   assign train_clr = !(state_q == ST_TRAIN && enable);
   assign skip_clr  = !(state_q == ST_RUN && enable);

   phy_tx_wrap_cnt #(.MAX(TRAIN_LEN)) u_train_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (train_clr),
      .inc   (1'b1),
      .tc    (train_tc)
   );

   phy_tx_wrap_cnt #(.MAX(SKIP_INTERVAL)) u_skip_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (skip_clr),
      .inc   (1'b1),
      .tc    (skip_due)
   );

   assign in_ready = reset && enable && (state_q == ST_RUN) && !skip_due;

   always_comb begin
      state_d   = state_q;
      data_d    = '0;
      valid_d   = 1'b0;
      k_d       = 1'b0;
      link_up_d = 1'b0;
      words_d   = words_q;

      unique case (state_q)
         ST_DOWN: begin
            if (enable) state_d = ST_TRAIN;
         end
         ST_TRAIN: begin
            if (!enable) begin
               state_d = ST_DOWN;
            end else begin
               data_d  = rep4(COM_SYM);
               valid_d = 1'b1;
               k_d     = 1'b1;
               if (train_tc) state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!enable) begin
               state_d = ST_DOWN;
            end else begin
               valid_d   = 1'b1;
               link_up_d = 1'b1;
               if (skip_due) begin
                  data_d = rep4(SKP_SYM);
                  k_d    = 1'b1;
               end else if (in_valid) begin
                  data_d  = in_data;
                  words_d = words_q + 16'd1;
               end else begin
                  data_d = rep4(IDL_SYM);
                  k_d    = 1'b1;
               end
            end
         end
         default: state_d = ST_DOWN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= ST_DOWN;
         data_q    <= '0;
         valid_q   <= 1'b0;
         k_q       <= 1'b0;
         link_up_q <= 1'b0;
         words_q   <= '0;
      end else begin
         state_q   <= state_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         k_q       <= k_d;
         link_up_q <= link_up_d;
         words_q   <= words_d;
      end
   end

   assign data_out   = data_q;
   assign valid_out  = valid_q;
   assign k_out      = k_q;
   assign link_up    = link_up_q;
   assign words_sent = words_q;

endmodule

// File: tb/tb_phy_tx_link_ctrl.sv
// Randomised bench for phy_tx_link_ctrl against a phase-counting reference
// model, with an AXI-style requester that holds each word until accepted.
module tb_phy_tx_link_ctrl;
   import phy_tx_pkg::*;

   localparam int TL = 16;
   localparam int SI = 64;
   localparam logic [31:0] COM_W = 32'hBCBCBCBC;
   localparam logic [31:0] IDL_W = 32'h7C7C7C7C;
   localparam logic [31:0] SKP_W = 32'h1C1C1C1C;

   logic        clk = 1'b0;
   logic        reset, enable, in_valid, in_ready;
   logic        valid_out, k_out, link_up;
   logic [31:0] in_data, data_out;
   logic [15:0] words_sent;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: mode 0=down, 1=training, 2=running; m_cnt counts
   // cycles spent in the current mode.
   int          m_mode = 0;
   int          m_cnt  = 0;
   logic        m_ready;
   logic [31:0] e_data  = '0;
   logic        e_valid = 1'b0;
   logic        e_k     = 1'b0;
   logic        e_link  = 1'b0;
   logic [15:0] e_words = '0;
   logic        last_acc = 1'b0;
   int          com_seen = 0;
   int          skp_seen = 0;

   always #5 clk = ~clk;

   phy_tx_link_ctrl #(.TRAIN_LEN(TL), .SKIP_INTERVAL(SI)) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .data_out   (data_out),
      .valid_out  (valid_out),
      .k_out      (k_out),
      .link_up    (link_up),
      .words_sent (words_sent)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
   endtask

   // One clock: check in_ready before the edge, advance the model, check outputs after.
   task automatic step();
      #1;
      m_ready = reset && enable && (m_mode == 2) && ((m_cnt % SI) != SI - 1);
      check("in_ready", 32'(in_ready), 32'(m_ready));
      last_acc = in_valid && m_ready;

      if (!reset) begin
         m_mode = 0; m_cnt = 0; e_words = '0;
         e_data = '0; e_valid = 0; e_k = 0; e_link = 0;
      end else if (m_mode == 0 || !enable) begin
         e_data = '0; e_valid = 0; e_k = 0; e_link = 0;
         if (m_mode == 0 && enable) begin
            m_mode = 1; m_cnt = 0;
         end else begin
            m_mode = 0; m_cnt = 0;
         end
      end else if (m_mode == 1) begin
         e_data = COM_W; e_valid = 1; e_k = 1; e_link = 0;
         m_cnt++;
         if (m_cnt == TL) begin
            m_mode = 2; m_cnt = 0;
         end
      end else begin
         e_valid = 1; e_link = 1;
         if ((m_cnt % SI) == SI - 1) begin
            e_data = SKP_W; e_k = 1;
         end else if (in_valid) begin
            e_data = in_data; e_k = 0; e_words = e_words + 16'd1;
         end else begin
            e_data = IDL_W; e_k = 1;
         end
         m_cnt++;
      end

      @(posedge clk);
      #1;
      check("data_out",   data_out,          e_data);
      check("valid_out",  32'(valid_out),    32'(e_valid));
      check("k_out",      32'(k_out),        32'(e_k));
      check("link_up",    32'(link_up),      32'(e_link));
      check("words_sent", 32'(words_sent),   32'(e_words));
      if (k_out && data_out == COM_W) com_seen++;
      if (k_out && data_out == SKP_W) skp_seen++;
   endtask

   // Requester offers a new word only once the previous one was taken.
   task automatic drive_req(input int valid_pct);
      if (!in_valid || last_acc) begin
         in_valid = ($urandom_range(99) < valid_pct);
         in_data  = $urandom;
      end
   endtask

   initial begin
      reset = 1'b0; enable = 1'b1; in_valid = 1'b0; in_data = '0;

      repeat (3) step();
      check("rst_data_out", data_out, 32'd0);

      reset = 1'b1;
      com_seen = 0;
      repeat (18) step();
      check("train_com_count", 32'(com_seen), 32'd16);
      check("first_run_idle", data_out, IDL_W);
      check("first_run_link", 32'(link_up), 32'd1);

      in_valid = 1'b1; in_data = 32'hDEADBEEF;
      step();
      check("word0_out", data_out, 32'hDEADBEEF);
      in_data = 32'h01234567;
      step();
      check("word1_out", data_out, 32'h01234567);
      in_valid = 1'b0;
      step();
      check("words_after_two", 32'(words_sent), 32'd2);

      skp_seen = 0;
      repeat (160) begin
         drive_req(90);
         step();
      end
      check("skp_count_160", 32'(skp_seen), 32'd2);

      in_valid = 1'b0;
      enable = 1'b0; step();
      enable = 1'b1; step();
      repeat (5) step();
      enable = 1'b0; step();
      check("drop_mid_train_valid", 32'(valid_out), 32'd0);
      enable = 1'b1;
      com_seen = 0;
      repeat (20) step();
      check("retrain_com_count", 32'(com_seen), 32'd16);

      repeat (10) begin
         drive_req(100);
         step();
      end
      drive_req(100);
      reset = 1'b0;
      step();
      check("rst_in_run_words", 32'(words_sent), 32'd0);
      check("rst_in_run_valid", 32'(valid_out), 32'd0);
      reset = 1'b1;

      repeat (3000) begin
         if ($urandom_range(149) == 0) enable = ~enable;
         reset = ($urandom_range(499) != 0);
         drive_req(70);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
